dmem_dma_ctrl: RTL and testbench
================================

DMEM_DMA_CTRL -- requirements
Module: dmem_dma_ctrl

Interface
REQ-001 Parameter AW, default 5, meaning word-address width of the data memory; it holds 2^AW words.
REQ-002 clk  input  1  system clock; memory writes and all block state update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a block copy.
REQ-005 src  input  AW  first source word address of the copy.
REQ-006 dst  input  AW  first destination word address of the copy.
REQ-007 len  input  AW+1  number of words to copy.
REQ-008 busy  output  1  high while a copy is in progress (states RD, WR).
REQ-009 done  output  1  one-cycle pulse when a copy completes.
REQ-010 cpu_req  input  1  CPU access this cycle (load or store); has absolute priority.
REQ-011 cpu_we  input  1  CPU store enable.
REQ-012 cpu_addr  input  32  CPU word address.
REQ-013 cpu_wd  input  32  CPU store data.
REQ-014 cpu_rd  output  32  CPU load data; combinational copy of mem_rd.
REQ-015 mem_we  output  1  data memory write enable.
REQ-016 mem_a  output  32  data memory word address.
REQ-017 mem_wd  output  32  data memory write data.
REQ-018 mem_rd  input  32  data memory combinational read data.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR and DONE.
REQ-020 In IDLE, start=1 SHALL latch src, dst and min(len, 2^AW) into src_ptr, dst_ptr and cnt; next state RD if the latched count is nonzero, else DONE.
REQ-021 start SHALL be ignored in RD, WR and DONE.
REQ-022 When cpu_req=1, mem_we=cpu_we, mem_a=cpu_addr and mem_wd=cpu_wd in every state, and the FSM SHALL hold its state and pointers.
REQ-023 In RD with cpu_req=0: mem_we=0, mem_a=src_ptr (zero-extended); at the clock edge mem_rd is captured into buf and the next state is WR.
REQ-024 In WR with cpu_req=0: mem_we=1, mem_a=dst_ptr, mem_wd=buf; at the clock edge src_ptr and dst_ptr increment modulo 2^AW and cnt decrements.
REQ-025 In WR with cpu_req=0, the next state SHALL be DONE if cnt==1, else RD.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 In IDLE or DONE with cpu_req=0: mem_we=0, mem_a=cpu_addr, mem_wd=cpu_wd.
REQ-028 Copy order SHALL be ascending, one word at a time (read, then write); overlapping ranges follow this order with no special handling.
REQ-029 An uncontended N-word copy SHALL take 2N cycles in RD/WR; each cycle with cpu_req=1 adds one cycle.
REQ-030 busy SHALL be a registered decode of the state (RD or WR).

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0 and clear src_ptr, dst_ptr, cnt and buf, independent of clk.
REQ-032 A reset during a copy SHALL abort it; no further DMA writes occur, and words already written remain.
REQ-033 During reset mem_we SHALL follow the cpu_req/cpu_we mux only (no DMA write).

Verification
REQ-034 Memory words 0..6 = 6,7,4,4,48,12,2; start with src=0, dst=10, len=3, cpu_req=0 -> words 10..12 = 6,7,4; done pulses in cycle 7 after start; busy is high for 6 cycles.
REQ-035 Same copy with cpu_req=1 for 2 cycles during WR -> CPU access proceeds unaltered, done is delayed by 2 cycles, destination data is identical.
REQ-036 src=30, dst=0, len=4 with words 30,31,0,1 = A,B,C,D -> words 0..3 = A,B,A,B (wrap plus overlap, ascending order).
REQ-037 len=0 -> done pulses the cycle after start, busy stays 0, no mem_we.
REQ-038 len=40 -> exactly 32 words copied (64 RD/WR cycles).
REQ-039 rst_n pulsed low after the second DMA write of a len=5 copy -> busy=0 at once, only 2 destination words changed, done is never asserted.

Source files
------------

// File: rtl/dmem_dma_ctrl.sv
// Word-copy DMA engine sharing the single data-memory port with the CPU.
// CPU accesses always win; the copy engine freezes in place while they occur.
module dmem_dma_ctrl #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wd,
  output logic [31:0]   cpu_rd,
  output logic          mem_we,
  output logic [31:0]   mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  localparam logic [AW:0] MAXW = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ZERO = '0;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   rbuf_q, rbuf_d;
  logic [AW:0]   len_c;

  // Requests longer than the memory are clamped to one full pass.
  assign len_c = (len > MAXW) ? MAXW : len;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    if (!cpu_req) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_d   = src;
            dst_d   = dst;
            cnt_d   = len_c;
            state_d = (len_c == ZERO) ? DONE : RD;
          end
        end
        RD: begin
          rbuf_d  = mem_rd;
          state_d = WR;
        end
        WR: begin
          src_d   = src_q + AW'(1);
          dst_d   = dst_q + AW'(1);
          cnt_d   = cnt_q - ONE;
          state_d = (cnt_q == ONE) ? DONE : RD;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RD) || (state_d == WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = cpu_addr;
    mem_wd = cpu_wd;
    if (cpu_req) begin
      mem_we = cpu_we;
    end else begin
      unique case (state_q)
        RD: mem_a = {{(32-AW){1'b0}}, src_q};
        WR: begin
          mem_we = 1'b1;
          mem_a  = {{(32-AW){1'b0}}, dst_q};
          mem_wd = rbuf_q;
        end
        default: ;
      endcase
    end
  end

  // DONE is held under a CPU access, so the pulse marks the cycle it retires.
  assign done   = (state_q == DONE) && !cpu_req;
  assign busy   = busy_q;
  assign cpu_rd = mem_rd;

endmodule

// File: tb/tb_dmem_dma_ctrl.sv
// Bench for dmem_dma_ctrl: behavioural memory, queued expectations,
// negedge monitor that pops and compares DMA writes, CPU loads and done.
module tb_dmem_dma_ctrl;
  localparam int AW = 5;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wd = '0;
  logic [31:0]   cpu_rd;
  logic          mem_we;
  logic [31:0]   mem_a, mem_wd, mem_rd;

  logic [31:0] mem  [32];
  logic [31:0] gold [32];
  logic [31:0] init7 [7];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_tot = 0;
  int t0 = 0;

  wr_t         wq[$];
  int          dq[$];
  logic [31:0] rq[$];

  dmem_dma_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_a[4:0]] <= mem_wd;
  assign mem_rd = mem[mem_a[4:0]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // All stimulus tasks start and end just after a rising edge.
  task automatic cpu_wr(input int a, input logic [31:0] d);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_wd = d;
    gold[a%32] = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic cpu_ld(input int a, input logic [31:0] exp);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = a;
    rq.push_back(exp);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic launch(input int s, input int d, input int l,
                        input int stall, input int nkeep);
    int n;
    int sa;
    int da;
    n = (l > 32) ? 32 : l;
    src = AW'(s);
    dst = AW'(d);
    len = (AW+1)'(l);
    start = 1'b1;
    for (int i = 0; i < n && i < nkeep; i++) begin
      sa = (s + i) % 32;
      da = (d + i) % 32;
      gold[da] = gold[sa];
      wq.push_back('{5'(da), gold[da]});
    end
    if (nkeep >= n) dq.push_back(cyc + 2*n + 1 + stall);
    t0 = busy_tot;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int busy_exp);
    int i;
    i = 0;
    while (dq.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    checks++;
    if (dq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: done pending %0d expected 0", nm, dq.size());
      dq.delete();
    end
    chk({nm, "_busy"}, busy_tot - t0, busy_exp);
    chk({nm, "_wq"}, wq.size(), 0);
  endtask

  initial begin
    init7 = '{32'd6, 32'd7, 32'd4, 32'd4, 32'd48, 32'd12, 32'd2};
    fork
      begin : monitor
        wr_t e;
        forever begin
          @(negedge clk);
          if (busy) busy_tot++;
          if (cpu_req) begin
            chk("cpu_mux_we", mem_we, cpu_we);
            chk("cpu_mux_a", mem_a, cpu_addr);
            chk("cpu_mux_wd", mem_wd, cpu_wd);
            if (!cpu_we) begin
              if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_rd: unexpected load %0h", cpu_rd);
              end else chk("cpu_rd", cpu_rd, rq.pop_front());
            end
          end else if (mem_we) begin
            if (wq.size() == 0) begin
              checks++; errors++;
              $display("FAIL dma_wr: unexpected write a=%0h d=%0h",
                       mem_a, mem_wd);
            end else begin
              e = wq.pop_front();
              chk("dma_wa", mem_a, {27'b0, e.a});
              chk("dma_wd", mem_wd, e.d);
            end
          end
          if (done) begin
            if (dq.size() == 0) begin
              checks++; errors++;
              $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else chk("done_cyc", cyc, dq.pop_front());
          end
        end
      end
      begin : stim
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_we", mem_we, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++)
          cpu_wr(i, (i < 7) ? init7[i] : 32'h100 + i);

        // Basic three-word copy
        launch(0, 10, 3, 0, 99);
        wait_done("copy3", 6);
        cpu_ld(10, 6); cpu_ld(11, 7); cpu_ld(12, 4);

        // Same copy with two CPU cycles stealing the port during WR
        cpu_wr(10, 0); cpu_wr(11, 0); cpu_wr(12, 0);
        launch(0, 10, 3, 2, 99);
        @(posedge clk); #1;
        cpu_wr(20, 32'h55AA);
        cpu_ld(20, 32'h55AA);
        wait_done("stall", 8);
        cpu_ld(10, 6); cpu_ld(11, 7); cpu_ld(12, 4);

        // Zero length
        launch(5, 15, 0, 0, 99);
        wait_done("len0", 0);
        cpu_ld(15, 32'h10F);

        // Reset after the second write of a five-word copy
        for (int i = 20; i < 25; i++) cpu_wr(i, 32'hAA);
        launch(0, 20, 5, 0, 2);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_wq", wq.size(), 0);
        cpu_ld(20, 6); cpu_ld(21, 7); cpu_ld(22, 32'hAA);
        cpu_ld(23, 32'hAA); cpu_ld(24, 32'hAA);

        // Oversized length clamps to one full pass
        launch(0, 16, 40, 0, 99);
        wait_done("len40", 64);
        cpu_ld(16, 6); cpu_ld(20, 48); cpu_ld(31, 32'h10F); cpu_ld(0, 6);

        // Wrap-around with overlapping ranges
        cpu_wr(30, 32'hA); cpu_wr(31, 32'hB);
        cpu_wr(0, 32'hC); cpu_wr(1, 32'hD);
        launch(30, 0, 4, 0, 99);
        wait_done("wrap", 8);
        cpu_ld(0, 32'hA); cpu_ld(1, 32'hB);
        cpu_ld(2, 32'hA); cpu_ld(3, 32'hB);

        repeat (2) @(posedge clk);
        #1;
        chk("rq_empty", rq.size(), 0);
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
